// File: rtl/alu_ctrl_pkg.sv
// Shared constants and FSM state type for the sequenced ALU control decoder.
package alu_ctrl_pkg;

  localparam logic [1:0] OP_RTYPE = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SUB   = 2'd2;
  localparam logic [1:0] OP_ITYPE = 2'd3;

  localparam int CTRL_ADD = 0;
  localparam int CTRL_SUB = 1;
  localparam int CTRL_AND = 2;
  localparam int CTRL_OR  = 3;
  localparam int CTRL_XOR = 4;
  localparam int CTRL_SLL = 5;
  localparam int CTRL_SRL = 6;
  localparam int CTRL_SRA = 7;

  // Codes at or above this value drive the iterative shifter.
  localparam int SHIFT_FIRST = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/fn_code decoder; flags shift-class and undefined encodings.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FN_W       = 5,
  parameter int CTRL_W     = 3,
  parameter int ITER_SHIFT = 1
) (
  input  logic [1:0]        alu_op,
  input  logic [FN_W-1:0]   fn_code,
  output logic [CTRL_W-1:0] ctrl,
  output logic              is_shift,
  output logic              is_illegal
);

  always_comb begin
    ctrl       = '0;
    is_illegal = 1'b0;
    case (alu_op)
      OP_RTYPE: begin
        if (32'(fn_code) < 32'd8) ctrl = CTRL_W'(32'(fn_code));
        else                      is_illegal = 1'b1;
      end
      OP_ADD: ctrl = CTRL_W'(CTRL_ADD);
      OP_SUB: ctrl = CTRL_W'(CTRL_SUB);
      default: begin
        // I-type ops map fn_code 0..2 onto the logic codes AND/OR/XOR.
        if (32'(fn_code) < 32'd3) ctrl = CTRL_W'(32'(fn_code) + CTRL_AND);
        else                      is_illegal = 1'b1;
      end
    endcase
    is_shift = (ITER_SHIFT != 0) && !is_illegal && (32'(ctrl) >= SHIFT_FIRST);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with one-bit-per-cycle shift sequencing and valid/ready stall.
// Optional macro ALU_CTRL_ILLEGAL_EN adds the illegal pulse and zeroes undefined codes.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FN_W       = 5,
  parameter int CTRL_W     = 3,
  parameter int SHAMT_W    = 5,
  parameter int ITER_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FN_W-1:0]    fn_code,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               shift_en,
  output logic               done
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic               illegal
`endif
);

  state_e               r_state, w_state_nxt;
  logic [SHAMT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CTRL_W-1:0]    r_ctrl, w_ctrl_nxt;
  logic [CTRL_W-1:0]    w_dec_ctrl;
  logic                 w_is_shift, w_illegal, w_accept;

  alu_ctrl_decode #(.FN_W(FN_W), .CTRL_W(CTRL_W), .ITER_SHIFT(ITER_SHIFT)) u_dec (
    .alu_op     (alu_op),
    .fn_code    (fn_code),
    .ctrl       (w_dec_ctrl),
    .is_shift   (w_is_shift),
    .is_illegal (w_illegal)
  );

  assign w_accept = in_valid && (r_state != SHIFT);
  assign in_ready = (r_state != SHIFT);
  assign shift_en = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign alu_ctrl = r_ctrl;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic r_ill, w_ill_nxt;
  assign illegal = r_ill && (r_state == DONE);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl_nxt  = r_ctrl;
`ifdef ALU_CTRL_ILLEGAL_EN
    w_ill_nxt   = r_ill;
`endif
    case (r_state)
      SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - SHAMT_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: ;
    endcase
    // Accept from IDLE or DONE overrides the default progression (back-to-back).
    if (w_accept) begin
      w_state_nxt = DONE;
`ifdef ALU_CTRL_ILLEGAL_EN
      w_ill_nxt  = w_illegal;
      w_ctrl_nxt = w_dec_ctrl;
`else
      if (!w_illegal) w_ctrl_nxt = w_dec_ctrl;
`endif
      if (w_is_shift && (shamt != '0)) begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = shamt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ctrl  <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
      r_ill   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
`ifdef ALU_CTRL_ILLEGAL_EN
      r_ill   <= w_ill_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: expected ops queued on accept, checked on done.
module tb_alu_ctrl_seq;

  typedef struct {
    logic [2:0] ctrl;
    int         nshift;
    logic       ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] alu_op = '0;
  logic [4:0] fn_code = '0;
  logic [4:0] shamt = '0;
  logic [2:0] alu_ctrl;
  logic       shift_en;
  logic       done;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       illegal;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   scnt  = 0;
  exp_t sb[$];
  logic [2:0] m_ctrl = '0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .fn_code  (fn_code),
    .shamt    (shamt),
    .alu_ctrl (alu_ctrl),
    .shift_en (shift_en),
    .done     (done)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal  (illegal)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [4:0] fn,
                                 input logic [4:0] sh, input logic [2:0] prev);
    exp_t e;
    logic legal;
    logic [2:0] c;
    legal = 1'b1;
    c = 3'd0;
    case (op)
      2'd0: if (fn < 5'd8) c = fn[2:0]; else legal = 1'b0;
      2'd1: c = 3'd0;
      2'd2: c = 3'd1;
      default: begin
        if (fn == 5'd0) c = 3'd2;
        else if (fn == 5'd1) c = 3'd3;
        else if (fn == 5'd2) c = 3'd4;
        else legal = 1'b0;
      end
    endcase
    e.ill = 1'b0;
    e.nshift = 0;
    if (legal) begin
      e.ctrl = c;
      if (c >= 3'd5) e.nshift = int'(sh);
    end else begin
`ifdef ALU_CTRL_ILLEGAL_EN
      e.ctrl = 3'd0;
      e.ill  = 1'b1;
`else
      e.ctrl = prev;
`endif
    end
    return e;
  endfunction

  // Call at #1 after a rising edge; returns one cycle after the accept edge.
  task automatic send(input logic [1:0] op, input logic [4:0] fn, input logic [4:0] sh,
                      output int waited, output logic acc_done);
    exp_t e;
    int w;
    w = 0;
    alu_op = op; fn_code = fn; shamt = sh; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    acc_done = done;
    if (!in_ready) begin
      chk("rdy_timeout", 32'd0, 32'd1);
    end else begin
      e = model(op, fn, sh, m_ctrl);
      m_ctrl = e.ctrl;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    waited = w;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      scnt = 0;
      sb.delete();
    end else begin
      if (shift_en) begin
        scnt++;
        chk("rdy_low", 32'(in_ready), 32'd0);
        if (sb.size() > 0) chk("sh_ctrl", 32'(alu_ctrl), 32'(sb[0].ctrl));
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spur_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ctrl", 32'(alu_ctrl), 32'(e.ctrl));
          chk("nshift", 32'(scnt), 32'(e.nshift));
`ifdef ALU_CTRL_ILLEGAL_EN
          chk("illegal", 32'(illegal), 32'(e.ill));
`endif
        end
        scnt = 0;
      end
    end
  end

  initial begin
    int   w;
    logic ad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_shen", 32'(shift_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("rst_ill", 32'(illegal), 32'd0);
`endif
    rst = 1'b0;
    m_ctrl = '0;
    @(posedge clk); #1;

    // single non-shift op, done one cycle later
    send(2'd0, 5'd3, 5'd9, w, ad);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_ctrl", 32'(alu_ctrl), 32'd3);
    @(posedge clk); #1;

    // back-to-back ops with no stall
    send(2'd3, 5'd2, 5'd0, w, ad);
    chk("t2_wait0", 32'(w), 32'd0);
    send(2'd2, 5'd0, 5'd0, w, ad);
    chk("t2_wait1", 32'(w), 32'd0);
    chk("t2_ctrl", 32'(alu_ctrl), 32'd1);
    @(posedge clk); #1;

    // shift of 4 with a request held through the stall
    send(2'd0, 5'd6, 5'd4, w, ad);
    send(2'd1, 5'd0, 5'd0, w, ad);
    chk("t3_stall", 32'(w), 32'd4);
    chk("t3_accdone", 32'(ad), 32'd1);
    @(posedge clk); #1;

    // shamt boundaries
    send(2'd0, 5'd5, 5'd0, w, ad);
    send(2'd0, 5'd7, 5'd31, w, ad);
    send(2'd2, 5'd0, 5'd0, w, ad);
    chk("t4_stall31", 32'(w), 32'd31);
    @(posedge clk); #1;

    // reset on the second shift cycle aborts without done
    send(2'd0, 5'd6, 5'd8, w, ad);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ab_ctrl", 32'(alu_ctrl), 32'd0);
    chk("ab_shen", 32'(shift_en), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_rdy", 32'(in_ready), 32'd1);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("ab_ill", 32'(illegal), 32'd0);
`endif
    rst = 1'b0;
    m_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;

    // undefined encoding after a known ctrl value
    send(2'd0, 5'd6, 5'd0, w, ad);
    send(2'd3, 5'd9, 5'd3, w, ad);
    chk("ill_done", 32'(done), 32'd1);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("ill_ctrl", 32'(alu_ctrl), 32'd0);
`else
    chk("ill_ctrl", 32'(alu_ctrl), 32'd6);
`endif
    @(posedge clk); #1;

    // random mix
    for (int i = 0; i < 24; i++) begin
      send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 3)), w, ad);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    begin
      int t;
      t = 0;
      while (sb.size() > 0 && t < 64) begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
